// File: rtl/nr_div_pkg.sv
// Shared types and helpers for the sequential non-restoring divider.
// Optional signed support is enabled by defining NR_DIV_SIGNED_EN.
package nr_div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  // Two's-complement magnitude of a value when negate is set; callers
  // truncate the result back to their own operand width.
  function automatic logic [31:0] abs_val(input logic [31:0] value, input logic negate);
    return negate ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One add/subtract row of the non-restoring divider, WIDTH+1 bits wide.
// The controller drives it with the shifted partial remainder while
// iterating, and with the raw partial remainder (sub=0) for the final fix.
module nr_div_step
  import nr_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] p,
  input  logic [WIDTH:0] d,
  input  logic           sub,
  output logic [WIDTH:0] p_next,
  output logic           q_bit
);

  // Subtract or add the divisor; a non-negative result yields a 1 quotient bit
  always_comb begin
    p_next = sub ? (p - d) : (p + d);
    q_bit  = ~p_next[WIDTH];
  end

endmodule

// File: rtl/nr_div_seq_ctrl.sv
// Sequential non-restoring divider controller: accepts operands on a
// valid/ready handshake, runs one shared add/subtract row per cycle for
// WIDTH cycles, corrects the remainder, and presents the result on a
// second valid/ready handshake.
// Defining NR_DIV_SIGNED_EN adds the is_signed request input and
// truncating signed division.
module nr_div_seq_ctrl
  import nr_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef NR_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH:0]   d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   step_p;
  logic [WIDTH:0]   step_p_next;
  logic             step_sub;
  logic             step_q_bit;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] rem_fixed;

`ifdef NR_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic neg_q_load;
  logic neg_r_load;

  assign neg_r_load   = is_signed & dividend[WIDTH-1];
  assign neg_q_load   = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  assign dividend_mag = WIDTH'(abs_val(32'(dividend), neg_r_load));
  assign divisor_mag  = WIDTH'(abs_val(32'(divisor), is_signed & divisor[WIDTH-1]));
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  // Magnitude remainder after correcting a negative partial remainder
  assign rem_fixed = p_reg[WIDTH] ? step_p_next[WIDTH-1:0] : p_reg[WIDTH-1:0];

  nr_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p     (step_p),
    .d     (d_reg),
    .sub   (step_sub),
    .p_next(step_p_next),
    .q_bit (step_q_bit)
  );

  // Feed the row with {P,Q}<<1 while iterating, otherwise with P for an add-back
  always_comb begin
    step_p   = p_reg;
    step_sub = 1'b0;
    if (state == ITER) begin
      step_p   = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      step_sub = ~p_reg[WIDTH];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = (divisor == '0) ? DONE : ITER;
        end
      end
      ITER: begin
        if (cnt == CNT_W'(1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand load, one row per iteration, final fix-up into the result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      p_reg       <= '0;
      d_reg       <= '0;
      q_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef NR_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              p_reg <= '0;
              q_reg <= dividend_mag;
              d_reg <= {1'b0, divisor_mag};
              cnt   <= CNT_W'(WIDTH);
`ifdef NR_DIV_SIGNED_EN
              neg_q <= neg_q_load;
              neg_r <= neg_r_load;
`endif
            end
          end
        end
        ITER: begin
          p_reg <= step_p_next;
          q_reg <= {q_reg[WIDTH-2:0], step_q_bit};
          cnt   <= cnt - CNT_W'(1);
        end
        FIX: begin
          p_reg       <= p_reg[WIDTH] ? step_p_next : p_reg;
          div_by_zero <= 1'b0;
`ifdef NR_DIV_SIGNED_EN
          quotient    <= neg_q ? (-q_reg) : q_reg;
          remainder   <= neg_r ? (-rem_fixed) : rem_fixed;
`else
          quotient    <= q_reg;
          remainder   <= rem_fixed;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nr_div_seq_ctrl.sv
// Self-checking bench for nr_div_seq_ctrl (WIDTH=16) using a result scoreboard.
// Signed scenarios are exercised when NR_DIV_SIGNED_EN is defined.
module tb_nr_div_seq_ctrl;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        busy;
`ifdef NR_DIV_SIGNED_EN
  logic        is_signed_in = 1'b0;
`endif

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  nr_div_seq_ctrl #(
    .WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef NR_DIV_SIGNED_EN
    .is_signed  (is_signed_in),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Global watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one request, wait (bounded) for acceptance, push its expectation
  task automatic send_req(input logic [15:0] a, input logic [15:0] b, input exp_t e,
                          output bit ok);
    int guard;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(e);
    ok = 1'b1;
  endtask

  // Count clock edges after acceptance until out_valid, -1 on timeout
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!out_valid && cycles < 100);
    if (!out_valid) cycles = -1;
  endtask

  // Complete the output handshake
  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b q=%h r=%h dz=%b, need 1 0 0 0000 0000 0",
               in_ready, out_valid, busy, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_unsigned_table();
    vec_t tbl[$];
    exp_t e;
    bit   ok;
    int   cyc;
    tbl.push_back('{16'd100, 16'd7, 16'd14, 16'd2});
    tbl.push_back('{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000});
    tbl.push_back('{16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE});
    tbl.push_back('{16'h0003, 16'hFFFF, 16'h0000, 16'h0003});
    for (int i = 0; i < 6; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = (i % 2 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 16'hFFFF));
      tbl.push_back('{a, b, a / b, a % b});
    end
    foreach (tbl[k]) begin
      send_req(tbl[k].a, tbl[k].b, '{tbl[k].q, tbl[k].r, 1'b0}, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("[TB] FAIL accept_%0d: in_ready stayed 0, need 1", k);
        continue;
      end
      wait_valid(cyc);
      compared++;
      if (cyc != 17) begin
        mismatched++;
        $display("[TB] FAIL latency_%0d: got %0d cycles, need 17", k, cyc);
      end
      e = sb.pop_front();
      compared++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        mismatched++;
        $display("[TB] FAIL result_%0d (%h/%h): q=%h r=%h dz=%b, need q=%h r=%h dz=%b",
                 k, tbl[k].a, tbl[k].b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      take_result();
      compared++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL handshake_%0d: out_valid=%b in_ready=%b, need 0 1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    bit   ok;
    int   cyc;
    send_req(16'd5, 16'd0, '{16'hFFFF, 16'd5, 1'b1}, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL dz_accept: in_ready stayed 0, need 1");
      return;
    end
    wait_valid(cyc);
    compared++;
    if (cyc != 1) begin
      mismatched++;
      $display("[TB] FAIL dz_latency: got %0d cycles, need 1", cyc);
    end
    e = sb.pop_front();
    compared++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
      mismatched++;
      $display("[TB] FAIL dz_result: q=%h r=%h dz=%b, need q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   ok;
    int   cyc;
    send_req(16'd3, 16'd10, '{16'd0, 16'd3, 1'b0}, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL bp_accept: in_ready stayed 0, need 1");
      return;
    end
    wait_valid(cyc);
    compared++;
    if (cyc != 17) begin
      mismatched++;
      $display("[TB] FAIL bp_latency: got %0d cycles, need 17", cyc);
    end
    e = sb.pop_front();
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz ||
          out_valid !== 1'b1 || in_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL bp_hold_%0d: q=%h r=%h dz=%b out_valid=%b in_ready=%b, need q=%h r=%h dz=%b 1 0",
                 i, quotient, remainder, div_by_zero, out_valid, in_ready, e.q, e.r, e.dz);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_no_reaccept: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    bit   ok;
    bit   seen;
    int   cyc;
    send_req(16'd1000, 16'd3, '{16'd333, 16'd1, 1'b0}, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL abort_accept: in_ready stayed 0, need 1");
      return;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || quotient !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL abort_reset: in_ready=%b out_valid=%b busy=%b q=%h, need 1 0 0 0000",
               in_ready, out_valid, busy, quotient);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("[TB] FAIL abort_no_valid: out_valid=1 seen, need 0");
    end
    send_req(16'd9, 16'd4, '{16'd2, 16'd1, 1'b0}, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL abort_next_accept: in_ready stayed 0, need 1");
      return;
    end
    wait_valid(cyc);
    e = sb.pop_front();
    compared++;
    if (cyc != 17 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
      mismatched++;
      $display("[TB] FAIL abort_next_result: cyc=%0d q=%h r=%h dz=%b, need 17 q=%h r=%h dz=%b",
               cyc, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    take_result();
  endtask

`ifdef NR_DIV_SIGNED_EN
  task automatic test_signed();
    vec_t tbl[$];
    logic sgn[$];
    exp_t e;
    bit   ok;
    int   cyc;
    tbl.push_back('{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF});
    sgn.push_back(1'b1);
    tbl.push_back('{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001});
    sgn.push_back(1'b1);
    tbl.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000});
    sgn.push_back(1'b1);
    tbl.push_back('{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE});
    sgn.push_back(1'b1);
    tbl.push_back('{16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001});
    sgn.push_back(1'b0);
    foreach (tbl[k]) begin
      is_signed_in = sgn[k];
      send_req(tbl[k].a, tbl[k].b, '{tbl[k].q, tbl[k].r, 1'b0}, ok);
      is_signed_in = 1'b0;
      compared++;
      if (!ok) begin
        mismatched++;
        $display("[TB] FAIL signed_accept_%0d: in_ready stayed 0, need 1", k);
        continue;
      end
      wait_valid(cyc);
      e = sb.pop_front();
      compared++;
      if (cyc != 17 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        mismatched++;
        $display("[TB] FAIL signed_%0d (%h/%h): cyc=%0d q=%h r=%h dz=%b, need 17 q=%h r=%h dz=%b",
                 k, tbl[k].a, tbl[k].b, cyc, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      take_result();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned_table();
    test_div_zero();
    test_backpressure();
    test_reset_abort();
`ifdef NR_DIV_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
